// File: rtl/seq_multiplier_if.sv
// Operand/result bundle shared by the execute-stage mult/div unit and its issue/writeback side.
// MUL_HIGH_EN adds product_hi carrying the upper half of the double-width product.
interface seq_multiplier_if #(
    parameter int WIDTH = 64
);
    logic             valid_in;
    logic             ready;
    logic             is_signed;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] product;
    logic             valid_out;
`ifdef MUL_HIGH_EN
    logic [WIDTH-1:0] product_hi;
`endif

    modport master (
        output valid_in, is_signed, multiplicand, multiplier,
        input  ready, product, valid_out
`ifdef MUL_HIGH_EN
        , input product_hi
`endif
    );

    modport slave (
        input  valid_in, is_signed, multiplicand, multiplier,
        output ready, product, valid_out
`ifdef MUL_HIGH_EN
        , output product_hi
`endif
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier on operand magnitudes with a final conditional negate.
// Define MUL_HIGH_EN to also produce the upper WIDTH bits on product_hi.
module seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_multiplier_if.slave mif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, ABS, CALC, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplr_reg;     // multiplier, shifted out as the low accumulator half fills
    logic [WIDTH-1:0] acc_hi_reg;
    logic [CW-1:0]    count_reg;
    logic             signed_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] product_reg;
    logic [WIDTH:0]   sum;
    logic             ready_c;
    logic             valid_out_c;

`ifdef MUL_HIGH_EN
    logic [WIDTH-1:0]   product_hi_reg;
    logic [2*WIDTH-1:0] full_prod;
    logic [2*WIDTH-1:0] fixed_prod;

    always_comb begin
        full_prod  = {acc_hi_reg, mplr_reg};
        fixed_prod = neg_reg ? -full_prod : full_prod;
    end

    assign mif.product_hi = product_hi_reg;
`else
    logic [WIDTH-1:0] fixed_lo;

    // Low half of a two's-complement negate depends only on the low half.
    always_comb begin
        fixed_lo = neg_reg ? -mplr_reg : mplr_reg;
    end
`endif

    always_comb begin
        sum = {1'b0, acc_hi_reg} + (mplr_reg[0] ? {1'b0, mcand_reg} : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ready_c     = 1'b0;
        valid_out_c = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_c = 1'b1;
                if (mif.valid_in) state_next = ABS;
            end
            ABS:  state_next = CALC;
            CALC: if (count_reg == LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: begin
                valid_out_c = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg      <= '0;
            mplr_reg       <= '0;
            acc_hi_reg     <= '0;
            count_reg      <= '0;
            signed_reg     <= 1'b0;
            neg_reg        <= 1'b0;
            product_reg    <= '0;
`ifdef MUL_HIGH_EN
            product_hi_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mif.valid_in) begin
                        mcand_reg  <= mif.multiplicand;
                        mplr_reg   <= mif.multiplier;
                        signed_reg <= mif.is_signed;
                    end
                end
                ABS: begin
                    // The magnitude of the most negative value still fits as unsigned.
                    if (signed_reg && mcand_reg[WIDTH-1]) mcand_reg <= -mcand_reg;
                    if (signed_reg && mplr_reg[WIDTH-1])  mplr_reg  <= -mplr_reg;
                    neg_reg    <= signed_reg & (mcand_reg[WIDTH-1] ^ mplr_reg[WIDTH-1]);
                    acc_hi_reg <= '0;
                    count_reg  <= '0;
                end
                CALC: begin
                    acc_hi_reg <= sum[WIDTH:1];
                    mplr_reg   <= {sum[0], mplr_reg[WIDTH-1:1]};
                    count_reg  <= count_reg + 1'b1;
                end
                FIX: begin
`ifdef MUL_HIGH_EN
                    product_reg    <= fixed_prod[WIDTH-1:0];
                    product_hi_reg <= fixed_prod[2*WIDTH-1:WIDTH];
`else
                    product_reg    <= fixed_lo;
`endif
                end
                default: ;
            endcase
        end
    end

    assign mif.ready     = ready_c;
    assign mif.valid_out = valid_out_c;
    assign mif.product   = product_reg;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: scoreboard of expected products checked on each valid_out.
module tb_seq_multiplier;
    localparam int W = 64;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_multiplier_if #(.WIDTH(W)) mif ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [127:0] ea, eb;
        ea = s ? {{64{a[W-1]}}, a} : {64'b0, a};
        eb = s ? {{64{b[W-1]}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        int   n = 0;
        exp_t e;
        while (mif.ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", mif.ready, 1'b1);
        mif.valid_in     = 1'b1;
        mif.multiplicand = a;
        mif.multiplier   = b;
        mif.is_signed    = s;
        @(negedge clk);
        mif.valid_in = 1'b0;
        e.lo      = exp_lo;
        e.hi      = exp_hi;
        e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_result(input string tag);
        int   n = 0;
        exp_t e;
        while (mif.valid_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, mif.valid_out, 1'b1);
        if (mif.valid_out === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, cyc - e.acc_cyc, W + 2);
            check({tag, "_lo"}, mif.product, e.lo);
`ifdef MUL_HIGH_EN
            check({tag, "_hi"}, mif.product_hi, e.hi);
`endif
            @(negedge clk);
            check({tag, "_pulse_end"}, mif.valid_out, 1'b0);
            check({tag, "_ready_back"}, mif.ready, 1'b1);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        $display("op %s: a=%h b=%h signed=%0d", tag, a, b, s);
        start_op(a, b, s, exp_lo, exp_hi);
        @(negedge clk);
        check({tag, "_busy"}, mif.ready, 1'b0);
        wait_result(tag);
    endtask

    task automatic run_model(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s);
        logic [127:0] m;
        m = model(a, b, s);
        run_op(tag, a, b, s, m[63:0], m[127:64]);
    endtask

    initial begin
        int pulses;
        logic [127:0] m;

        rst_n            = 1'b0;
        mif.valid_in     = 1'b1;
        mif.is_signed    = 1'b0;
        mif.multiplicand = 64'd7;
        mif.multiplier   = 64'd9;
        repeat (4) @(negedge clk);
        check("rst_ready", mif.ready, 1'b1);
        check("rst_valid_out", mif.valid_out, 1'b0);
        check("rst_product", mif.product, 64'h0);
`ifdef MUL_HIGH_EN
        check("rst_product_hi", mif.product_hi, 64'h0);
`endif
        mif.valid_in = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        check("post_rst_ready", mif.ready, 1'b1);

        run_op("s6xm7", 64'd6, -64'sd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("u_max_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
        run_op("s_m1_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("s_min_xm1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'h8000_0000_0000_0000, 64'h0);
        run_model("u_mixed", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
        run_model("s_mixed", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        run_model("s_negneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        run_model("zero", 64'h0, 64'hDEAD_BEEF_0000_1234, 1'b1);

        // A request while busy must be ignored and must not produce a second pulse.
        $display("op busy: first op then ignored 3*5");
        m = model(64'd1000, 64'd77, 1'b0);
        start_op(64'd1000, 64'd77, 1'b0, m[63:0], m[127:64]);
        repeat (10) @(negedge clk);
        mif.valid_in     = 1'b1;
        mif.multiplicand = 64'd3;
        mif.multiplier   = 64'd5;
        mif.is_signed    = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_ready", mif.ready, 1'b0);
        mif.valid_in = 1'b0;
        wait_result("busy_first");
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (mif.valid_out === 1'b1) pulses++;
        end
        check("busy_no_extra_pulse", pulses, 0);
        run_op("busy_3x5", 64'd3, 64'd5, 1'b0, 64'd15, 64'd0);

        // Abort in CALC iteration 20: reset clears everything and the op never completes.
        $display("op abort: 100*100 interrupted by reset");
        start_op(64'd100, 64'd100, 1'b0, 64'd10000, 64'd0);
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid_out", mif.valid_out, 1'b0);
        check("abort_product", mif.product, 64'h0);
        check("abort_ready", mif.ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_front());
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (mif.valid_out === 1'b1) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_product_held", mif.product, 64'h0);
        run_op("after_abort", 64'd100, 64'd100, 1'b0, 64'd10000, 64'd0);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
